// File: rtl/brq_regfile_mp_if.sv
// Bus bundle for the Buraq-mini multi-port register file: read ports,
// write ports, busy scoreboard access, debug read and conflict flag.
interface brq_regfile_mp_if #(
  parameter int DataWidth    = 32,
  parameter int AddrRegWidth = 5,
  parameter int NumRead      = 2,
  parameter int NumWrite     = 2
);
  localparam int NRegs = 2 ** AddrRegWidth;

  logic [NumRead*AddrRegWidth-1:0]  rd_addr_i;
  logic [NumRead*DataWidth-1:0]     rd_data_o;
  logic [NumWrite-1:0]              we_i;
  logic [NumWrite*AddrRegWidth-1:0] waddr_i;
  logic [NumWrite*DataWidth-1:0]    wdata_i;
  logic                             busy_set_i;
  logic [AddrRegWidth-1:0]          busy_addr_i;
  logic [NRegs-1:0]                 busy_o;
  logic [AddrRegWidth-1:0]          dbg_addr_i;
  logic [DataWidth-1:0]             dbg_data_o;
  logic                             wr_conflict_o;

  // Decode/writeback side drives addresses and data, samples results
  modport master (
    output rd_addr_i, we_i, waddr_i, wdata_i, busy_set_i, busy_addr_i, dbg_addr_i,
    input  rd_data_o, busy_o, dbg_data_o, wr_conflict_o
  );

  // Register file side
  modport slave (
    input  rd_addr_i, we_i, waddr_i, wdata_i, busy_set_i, busy_addr_i, dbg_addr_i,
    output rd_data_o, busy_o, dbg_data_o, wr_conflict_o
  );
endinterface

// File: rtl/brq_regfile_mp.sv
// Multi-port integer register file for Buraq-mini. Combinational reads with
// optional same-cycle write forwarding, higher-numbered write port wins on
// address collisions, per-register busy scoreboard, registered debug read.
module brq_regfile_mp #(
  parameter int                    DataWidth    = 32,
  parameter int                    AddrRegWidth = 5,
  parameter int                    NumRead      = 2,
  parameter int                    NumWrite     = 2,
  parameter bit                    Bypass       = 1'b1,
  parameter int                    SpIndex      = 2,
  parameter logic [DataWidth-1:0]  SpResetVal   = 32'h00000200
) (
  input  logic                brq_clk,
  input  logic                brq_rst_n,
  brq_regfile_mp_if.slave     bus
);
  localparam int NRegs = 2 ** AddrRegWidth;

  if (NumRead < 1 || NumRead > 4) begin : g_bad_num_read
    $error("brq_regfile_mp: NumRead must be in 1..4");
  end
  if (NumWrite < 1 || NumWrite > 2) begin : g_bad_num_write
    $error("brq_regfile_mp: NumWrite must be in 1..2");
  end

  logic [DataWidth-1:0]         regs_q [NRegs];
  logic [DataWidth-1:0]         regs_d [NRegs];
  logic [NRegs-1:0]             busy_q, busy_d;
  logic [DataWidth-1:0]         dbg_data_q, dbg_data_d;
  logic                         wr_conflict_q, wr_conflict_d;
  logic [NumRead*DataWidth-1:0] rd_data;

  // Apply write ports in ascending order so port 1 overrides port 0 on the same address
  always_comb begin : write_next
    logic [AddrRegWidth-1:0] w_addr;
    w_addr = '0;
    regs_d = regs_q;
    for (int p = 0; p < NumWrite; p++) begin
      w_addr = bus.waddr_i[p*AddrRegWidth +: AddrRegWidth];
      if (bus.we_i[p] && (w_addr != '0)) begin
        regs_d[w_addr] = bus.wdata_i[p*DataWidth +: DataWidth];
      end
    end
  end

  // Writes clear busy first, then an issue-stage set overrides since it is the newer producer
  always_comb begin : busy_next
    logic [AddrRegWidth-1:0] w_addr;
    w_addr = '0;
    busy_d = busy_q;
    for (int p = 0; p < NumWrite; p++) begin
      w_addr = bus.waddr_i[p*AddrRegWidth +: AddrRegWidth];
      if (bus.we_i[p]) begin
        busy_d[w_addr] = 1'b0;
      end
    end
    if (bus.busy_set_i && (bus.busy_addr_i != '0)) begin
      busy_d[bus.busy_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Flag any pair of enabled write ports hitting the same non-zero register
  always_comb begin : conflict_next
    wr_conflict_d = 1'b0;
    for (int p = 0; p < NumWrite; p++) begin
      for (int q = p + 1; q < NumWrite; q++) begin
        if (bus.we_i[p] && bus.we_i[q] &&
            (bus.waddr_i[p*AddrRegWidth +: AddrRegWidth] ==
             bus.waddr_i[q*AddrRegWidth +: AddrRegWidth]) &&
            (bus.waddr_i[p*AddrRegWidth +: AddrRegWidth] != '0)) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  // Combinational reads; with forwarding, the last matching write port supplies the data
  always_comb begin : read_ports
    logic [AddrRegWidth-1:0] r_addr;
    logic [DataWidth-1:0]    r_val;
    r_addr  = '0;
    r_val   = '0;
    rd_data = '0;
    for (int k = 0; k < NumRead; k++) begin
      r_addr = bus.rd_addr_i[k*AddrRegWidth +: AddrRegWidth];
      r_val  = (r_addr == '0) ? '0 : regs_q[r_addr];
      if (Bypass) begin
        for (int p = 0; p < NumWrite; p++) begin
          if (bus.we_i[p] && (r_addr != '0) &&
              (bus.waddr_i[p*AddrRegWidth +: AddrRegWidth] == r_addr)) begin
            r_val = bus.wdata_i[p*DataWidth +: DataWidth];
          end
        end
      end
      rd_data[k*DataWidth +: DataWidth] = r_val;
    end
  end

  // Debug port samples the stored (pre-write) value, never forwarded
  always_comb begin : debug_next
    dbg_data_d = (bus.dbg_addr_i == '0) ? '0 : regs_q[bus.dbg_addr_i];
  end

  // State registers; reset loads the stack pointer with its boot value
  always_ff @(posedge brq_clk or negedge brq_rst_n) begin
    if (!brq_rst_n) begin
      for (int r = 0; r < NRegs; r++) begin
        regs_q[r] <= (r == SpIndex) ? SpResetVal : '0;
      end
      busy_q        <= '0;
      dbg_data_q    <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      dbg_data_q    <= dbg_data_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign bus.rd_data_o     = rd_data;
  assign bus.busy_o        = busy_q;
  assign bus.dbg_data_o    = dbg_data_q;
  assign bus.wr_conflict_o = wr_conflict_q;

endmodule

// File: tb/tb_brq_regfile_mp.sv
// Bench for brq_regfile_mp: one forwarding and one non-forwarding instance
// driven by identical stimulus, expectations queued at drive time.
module tb_brq_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic brq_clk = 1'b0;
  logic brq_rst_n = 1'b1;

  // Free-running clock, period 10
  always #5 brq_clk = ~brq_clk;

  brq_regfile_mp_if #(.DataWidth(DW), .AddrRegWidth(AW), .NumRead(NR), .NumWrite(NW)) bus_byp ();
  brq_regfile_mp_if #(.DataWidth(DW), .AddrRegWidth(AW), .NumRead(NR), .NumWrite(NW)) bus_nob ();

  assign bus_nob.rd_addr_i   = bus_byp.rd_addr_i;
  assign bus_nob.we_i        = bus_byp.we_i;
  assign bus_nob.waddr_i     = bus_byp.waddr_i;
  assign bus_nob.wdata_i     = bus_byp.wdata_i;
  assign bus_nob.busy_set_i  = bus_byp.busy_set_i;
  assign bus_nob.busy_addr_i = bus_byp.busy_addr_i;
  assign bus_nob.dbg_addr_i  = bus_byp.dbg_addr_i;

  brq_regfile_mp #(.DataWidth(DW), .AddrRegWidth(AW), .NumRead(NR), .NumWrite(NW),
                   .Bypass(1'b1), .SpIndex(2), .SpResetVal(32'h00000200))
    dut_byp (.brq_clk(brq_clk), .brq_rst_n(brq_rst_n), .bus(bus_byp));

  brq_regfile_mp #(.DataWidth(DW), .AddrRegWidth(AW), .NumRead(NR), .NumWrite(NW),
                   .Bypass(1'b0), .SpIndex(2), .SpResetVal(32'h00000200))
    dut_nob (.brq_clk(brq_clk), .brq_rst_n(brq_rst_n), .bus(bus_nob));

  int vectors = 0;
  int miscompares = 0;

  string       name_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];

  task automatic expect_val(input string n, input logic [31:0] v);
    name_q.push_back(n);
    exp_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge brq_clk);
    #1;
  endtask

  task automatic set_write(input int p, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_byp.we_i[p] = en;
    bus_byp.waddr_i[p*AW +: AW] = a;
    bus_byp.wdata_i[p*DW +: DW] = d;
  endtask

  task automatic set_read(input int k, input logic [AW-1:0] a);
    bus_byp.rd_addr_i[k*AW +: AW] = a;
  endtask

  task automatic drive_idle();
    bus_byp.we_i        = '0;
    bus_byp.waddr_i     = '0;
    bus_byp.wdata_i     = '0;
    bus_byp.busy_set_i  = 1'b0;
    bus_byp.busy_addr_i = '0;
  endtask

  function automatic logic [31:0] rd_byp(input int k);
    return bus_byp.rd_data_o[k*DW +: DW];
  endfunction

  function automatic logic [31:0] rd_nob(input int k);
    return bus_nob.rd_data_o[k*DW +: DW];
  endfunction

  task automatic test_reset();
    string n; logic [31:0] e, a;
    drive_idle();
    bus_byp.rd_addr_i  = '0;
    bus_byp.dbg_addr_i = '0;
    #1 brq_rst_n = 1'b0;
    #1;
    for (int r = 0; r < 32; r++) begin
      set_read(0, AW'(r));
      set_read(1, AW'(r));
      expect_val($sformatf("reset_x%0d_byp_p0", r), (r == 2) ? 32'h200 : 32'h0);
      expect_val($sformatf("reset_x%0d_nob_p1", r), (r == 2) ? 32'h200 : 32'h0);
      #1;
      act_q.push_back(rd_byp(0));
      act_q.push_back(rd_nob(1));
    end
    expect_val("reset_busy", 32'h0);
    expect_val("reset_dbg", 32'h0);
    expect_val("reset_conflict", 32'h0);
    act_q.push_back(bus_byp.busy_o);
    act_q.push_back(bus_byp.dbg_data_o);
    act_q.push_back({31'b0, bus_byp.wr_conflict_o});
    @(negedge brq_clk);
    brq_rst_n = 1'b1;
    tick();
    while (act_q.size() > 0) begin
      n = name_q.pop_front(); e = exp_q.pop_front(); a = act_q.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("[TB] FAIL %s: got %08h expected %08h", n, a, e); end
    end
  endtask

  task automatic test_bypass();
    string n; logic [31:0] e, a;
    set_write(0, 1'b1, 5'd5, 32'hDEADBEEF);
    set_read(0, 5'd5);
    expect_val("bypass_same_cycle_byp", 32'hDEADBEEF);
    expect_val("bypass_same_cycle_nob", 32'h0);
    #1;
    act_q.push_back(rd_byp(0));
    act_q.push_back(rd_nob(0));
    tick();
    drive_idle();
    expect_val("bypass_next_cycle_byp", 32'hDEADBEEF);
    expect_val("bypass_next_cycle_nob", 32'hDEADBEEF);
    #1;
    act_q.push_back(rd_byp(0));
    act_q.push_back(rd_nob(0));
    while (act_q.size() > 0) begin
      n = name_q.pop_front(); e = exp_q.pop_front(); a = act_q.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("[TB] FAIL %s: got %08h expected %08h", n, a, e); end
    end
  endtask

  task automatic test_x0();
    string n; logic [31:0] e, a;
    set_write(0, 1'b1, 5'd0, 32'h12345678);
    set_write(1, 1'b1, 5'd0, 32'h12345678);
    set_read(0, 5'd0);
    set_read(1, 5'd0);
    expect_val("x0_fwd_p0", 32'h0);
    expect_val("x0_fwd_p1", 32'h0);
    #1;
    act_q.push_back(rd_byp(0));
    act_q.push_back(rd_byp(1));
    tick();
    drive_idle();
    expect_val("x0_stored", 32'h0);
    expect_val("x0_busy", 32'h0);
    expect_val("x0_conflict", 32'h0);
    #1;
    act_q.push_back(rd_nob(0));
    act_q.push_back({31'b0, bus_byp.busy_o[0]});
    act_q.push_back({31'b0, bus_byp.wr_conflict_o});
    while (act_q.size() > 0) begin
      n = name_q.pop_front(); e = exp_q.pop_front(); a = act_q.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("[TB] FAIL %s: got %08h expected %08h", n, a, e); end
    end
  endtask

  task automatic test_conflict();
    string n; logic [31:0] e, a;
    set_write(0, 1'b1, 5'd7, 32'hAAAA0000);
    set_write(1, 1'b1, 5'd7, 32'h5555FFFF);
    set_read(1, 5'd7);
    expect_val("conflict_fwd_winner", 32'h5555FFFF);
    expect_val("conflict_not_yet", 32'h0);
    #1;
    act_q.push_back(rd_byp(1));
    act_q.push_back({31'b0, bus_byp.wr_conflict_o});
    tick();
    drive_idle();
    expect_val("conflict_flag", 32'h1);
    expect_val("conflict_stored_winner", 32'h5555FFFF);
    #1;
    act_q.push_back({31'b0, bus_byp.wr_conflict_o});
    act_q.push_back(rd_nob(1));
    tick();
    expect_val("conflict_flag_drop", 32'h0);
    act_q.push_back({31'b0, bus_byp.wr_conflict_o});
    // Two ports, distinct registers: both land, no conflict
    set_write(0, 1'b1, 5'd12, 32'h00000111);
    set_write(1, 1'b1, 5'd13, 32'h00000222);
    tick();
    drive_idle();
    set_read(0, 5'd12);
    set_read(1, 5'd13);
    expect_val("dual_write_conflict", 32'h0);
    expect_val("dual_write_x12", 32'h00000111);
    expect_val("dual_write_x13", 32'h00000222);
    #1;
    act_q.push_back({31'b0, bus_byp.wr_conflict_o});
    act_q.push_back(rd_nob(0));
    act_q.push_back(rd_nob(1));
    while (act_q.size() > 0) begin
      n = name_q.pop_front(); e = exp_q.pop_front(); a = act_q.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("[TB] FAIL %s: got %08h expected %08h", n, a, e); end
    end
  endtask

  task automatic test_back_to_back();
    string n; logic [31:0] e, a;
    set_write(0, 1'b1, 5'd8, 32'h11111111);
    set_write(1, 1'b1, 5'd8, 32'h22222222);
    tick();
    set_write(0, 1'b1, 5'd10, 32'h33333333);
    set_write(1, 1'b1, 5'd10, 32'h44444444);
    expect_val("b2b_flag_first", 32'h1);
    act_q.push_back({31'b0, bus_byp.wr_conflict_o});
    tick();
    drive_idle();
    set_read(0, 5'd8);
    set_read(1, 5'd10);
    expect_val("b2b_flag_second", 32'h1);
    expect_val("b2b_x8", 32'h22222222);
    expect_val("b2b_x10", 32'h44444444);
    #1;
    act_q.push_back({31'b0, bus_byp.wr_conflict_o});
    act_q.push_back(rd_nob(0));
    act_q.push_back(rd_nob(1));
    tick();
    expect_val("b2b_flag_end", 32'h0);
    act_q.push_back({31'b0, bus_byp.wr_conflict_o});
    while (act_q.size() > 0) begin
      n = name_q.pop_front(); e = exp_q.pop_front(); a = act_q.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("[TB] FAIL %s: got %08h expected %08h", n, a, e); end
    end
  endtask

  task automatic test_scoreboard();
    string n; logic [31:0] e, a;
    bus_byp.busy_set_i  = 1'b1;
    bus_byp.busy_addr_i = 5'd9;
    tick();
    bus_byp.busy_set_i = 1'b0;
    expect_val("sb_set_x9", 32'h00000200);
    act_q.push_back(bus_byp.busy_o);
    // Write and re-issue in the same cycle: set wins
    set_write(0, 1'b1, 5'd9, 32'h00000099);
    bus_byp.busy_set_i  = 1'b1;
    bus_byp.busy_addr_i = 5'd9;
    expect_val("sb_no_bypass_same_cycle", 32'h1);
    #1;
    act_q.push_back({31'b0, bus_byp.busy_o[9]});
    tick();
    bus_byp.busy_set_i = 1'b0;
    expect_val("sb_set_beats_clear", 32'h1);
    act_q.push_back({31'b0, bus_byp.busy_o[9]});
    set_write(0, 1'b1, 5'd9, 32'h0000009A);
    expect_val("sb_clear_not_bypassed", 32'h1);
    #1;
    act_q.push_back({31'b0, bus_byp.busy_o[9]});
    tick();
    drive_idle();
    expect_val("sb_cleared", 32'h0);
    act_q.push_back(bus_byp.busy_o);
    // x0 can never become busy
    bus_byp.busy_set_i  = 1'b1;
    bus_byp.busy_addr_i = 5'd0;
    tick();
    bus_byp.busy_addr_i = 5'd4;
    expect_val("sb_x0_never_busy", 32'h0);
    act_q.push_back(bus_byp.busy_o);
    // Setting x4 twice keeps it busy; port 1 write clears it
    tick();
    tick();
    bus_byp.busy_set_i = 1'b0;
    expect_val("sb_double_set", 32'h00000010);
    act_q.push_back(bus_byp.busy_o);
    set_write(1, 1'b1, 5'd4, 32'h00000044);
    tick();
    drive_idle();
    expect_val("sb_port1_clear", 32'h0);
    act_q.push_back(bus_byp.busy_o);
    while (act_q.size() > 0) begin
      n = name_q.pop_front(); e = exp_q.pop_front(); a = act_q.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("[TB] FAIL %s: got %08h expected %08h", n, a, e); end
    end
  endtask

  task automatic test_debug();
    string n; logic [31:0] e, a;
    bus_byp.dbg_addr_i = 5'd5;
    expect_val("dbg_x5", 32'hDEADBEEF);
    tick();
    act_q.push_back(bus_byp.dbg_data_o);
    bus_byp.dbg_addr_i = 5'd11;
    set_write(0, 1'b1, 5'd11, 32'hCAFEF00D);
    expect_val("dbg_pre_write", 32'h0);
    tick();
    drive_idle();
    act_q.push_back(bus_byp.dbg_data_o);
    expect_val("dbg_post_write", 32'hCAFEF00D);
    tick();
    act_q.push_back(bus_byp.dbg_data_o);
    bus_byp.dbg_addr_i = 5'd2;
    expect_val("dbg_sp", 32'h00000200);
    tick();
    act_q.push_back(bus_byp.dbg_data_o);
    bus_byp.dbg_addr_i = 5'd7;
    expect_val("dbg_x7_winner", 32'h5555FFFF);
    tick();
    act_q.push_back(bus_nob.dbg_data_o);
    bus_byp.dbg_addr_i = 5'd0;
    expect_val("dbg_x0", 32'h0);
    tick();
    act_q.push_back(bus_byp.dbg_data_o);
    while (act_q.size() > 0) begin
      n = name_q.pop_front(); e = exp_q.pop_front(); a = act_q.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("[TB] FAIL %s: got %08h expected %08h", n, a, e); end
    end
  endtask

  task automatic test_async_reset();
    string n; logic [31:0] e, a;
    set_write(0, 1'b1, 5'd3, 32'h00000001);
    bus_byp.busy_set_i  = 1'b1;
    bus_byp.busy_addr_i = 5'd4;
    tick();
    drive_idle();
    set_read(0, 5'd3);
    expect_val("arst_x3_before", 32'h1);
    expect_val("arst_busy_before", 32'h00000010);
    #1;
    act_q.push_back(rd_nob(0));
    act_q.push_back(bus_byp.busy_o);
    // Pending write to x6 that reset must abort
    set_write(0, 1'b1, 5'd6, 32'h000000FF);
    #1 brq_rst_n = 1'b0;
    expect_val("arst_x3_immediate", 32'h0);
    expect_val("arst_busy_immediate", 32'h0);
    #1;
    act_q.push_back(rd_nob(0));
    act_q.push_back(bus_byp.busy_o);
    tick();
    set_read(1, 5'd6);
    expect_val("arst_write_aborted", 32'h0);
    #1;
    act_q.push_back(rd_nob(1));
    @(negedge brq_clk);
    set_write(0, 1'b1, 5'd6, 32'h00000077);
    brq_rst_n = 1'b1;
    tick();
    drive_idle();
    set_read(0, 5'd2);
    expect_val("arst_first_write", 32'h00000077);
    expect_val("arst_sp_restored", 32'h00000200);
    #1;
    act_q.push_back(rd_nob(1));
    act_q.push_back(rd_nob(0));
    while (act_q.size() > 0) begin
      n = name_q.pop_front(); e = exp_q.pop_front(); a = act_q.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("[TB] FAIL %s: got %08h expected %08h", n, a, e); end
    end
  endtask

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Scenario sequence
  initial begin
    drive_idle();
    bus_byp.rd_addr_i  = '0;
    bus_byp.dbg_addr_i = '0;
    test_reset();
    test_bypass();
    test_x0();
    test_conflict();
    test_back_to_back();
    test_scoreboard();
    test_debug();
    test_async_reset();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
